added_interp_2d_engine: RTL

ADDED_INTERP_2D_ENGINE -- requirements
Module: added_interp_2d_engine

---
 rtl/added_interp_2d_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/added_interp_2d_engine.sv
// added_interp_2d_engine: separable 8-tap quarter-sample interpolator.
// Each accepted input row is filtered horizontally into N_CH 16-bit
// intermediates, pushed into an 8-row sliding window, and once the window
// is full every new row yields one vertically filtered, saturated output row.
module added_interp_2d_engine #(
    parameter int N_CH     = 4,
    parameter int SAMPLE_W = 8,
    parameter int MAX_H    = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [1:0]                      FRAC_X,
    input  logic [1:0]                      FRAC_Y,
    input  logic [$clog2(MAX_H+1)-1:0]      BLK_H,
    input  logic                            IN_VALID,
    output logic                            IN_READY,
    input  logic [(N_CH+7)*SAMPLE_W-1:0]    IN_ROW,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [N_CH*16-1:0]              OUT_ROW,
    output logic                            OUT_LAST,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int HW    = $clog2(MAX_H + 1);
    localparam int CW    = $clog2(MAX_H + 7);
    localparam int P1_SH = SAMPLE_W - 8;
    localparam int P1_UP = 14 - SAMPLE_W;
    localparam logic [HW-1:0] MAX_H_V = HW'(MAX_H);

    // Coefficient sets indexed by the quarter-sample fraction; set 0 is the
    // integer position and is never used by the filter datapath.
    localparam int COEF [4][8] = '{
        '{ 0, 0,   0,  0,  0,   0, 0,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{ 0, 1,  -5, 17, 58, -10, 4, -1}
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [1:0]      frac_x_q, frac_x_d;
    logic [1:0]      frac_y_q, frac_y_d;
    logic [HW-1:0]   h_eff_q, h_eff_d;
    logic [N_CH*16-1:0] out_row_q, out_row_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;

    // Window row 0 is the oldest row (vertical tap 0), row 7 the newest.
    logic signed [15:0] window_q [8][N_CH];
    logic signed [15:0] window_d [8][N_CH];
    logic signed [15:0] win_new  [8][N_CH];

    logic signed [15:0] p1_row [N_CH];
    logic signed [15:0] p2_row [N_CH];
    logic [N_CH*16-1:0] p2_packed;

    logic          in_ready;
    logic          accept;
    logic          out_hs;
    logic [CW-1:0] last_row;
    logic [HW-1:0] blk_h_clamped;

    assign accept   = IN_VALID && in_ready;
    assign out_hs   = out_valid_q && OUT_READY;
    assign last_row = CW'(h_eff_q) + CW'(6);

    // Clamp the requested height into 1..MAX_H.
    always_comb begin
        if (BLK_H == '0) begin
            blk_h_clamped = HW'(1);
        end else if (BLK_H > MAX_H_V) begin
            blk_h_clamped = MAX_H_V;
        end else begin
            blk_h_clamped = BLK_H;
        end
    end

    // Horizontal pass: N_CH 8-tap filters over the incoming row.
    always_comb begin
        logic signed [23:0] acc;
        logic [SAMPLE_W-1:0] s;
        // NOTE: every variable gets a value on every path through an
        // always_comb block; a missing default silently infers a latch.
        acc = '0;
        s   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (frac_x_q == 2'd0) begin
                s         = IN_ROW[(c+3)*SAMPLE_W +: SAMPLE_W];
                p1_row[c] = $signed(16'(s) << P1_UP);
            end else begin
                acc = '0;
                for (int t = 0; t < 8; t++) begin
                    s   = IN_ROW[(c+t)*SAMPLE_W +: SAMPLE_W];
                    acc = acc + 24'(COEF[frac_x_q][t]) * $signed(24'(s));
                end
                p1_row[c] = 16'(acc >>> P1_SH);
            end
        end
    end

    // Window as it will look after the current row shifts in.
    always_comb begin
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                win_new[r][c] = window_q[r+1][c];
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            win_new[7][c] = p1_row[c];
        end
    end

    // Vertical pass over the updated window, saturated to 16-bit signed.
    always_comb begin
        logic signed [31:0] acc;
        logic signed [31:0] sh;
        acc       = '0;
        sh        = '0;
        p2_packed = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (frac_y_q == 2'd0) begin
                p2_row[c] = win_new[3][c];
            end else begin
                acc = '0;
                for (int t = 0; t < 8; t++) begin
                    acc = acc + 32'(COEF[frac_y_q][t]) * 32'(win_new[t][c]);
                end
                sh = acc >>> 6;
                if (sh > 32'sd32767) begin
                    p2_row[c] = 16'sh7fff;
                end else if (sh < -32'sd32768) begin
                    p2_row[c] = 16'sh8000;
                end else begin
                    p2_row[c] = 16'(sh);
                end
            end
            p2_packed[c*16 +: 16] = p2_row[c];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (START) state_d = ST_FILL;
            ST_FILL:  if (accept && row_cnt_q == CW'(6)) state_d = ST_RUN;
            ST_RUN:   if (accept && row_cnt_q == last_row) state_d = ST_FLUSH;
            ST_FLUSH: if (out_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: input backpressure and busy flag.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ST_FILL:  in_ready = 1'b1;
            ST_RUN:   in_ready = !out_valid_q || OUT_READY;
            default:  in_ready = 1'b0;
        endcase
        BUSY = (state_q != ST_IDLE);
    end

    // Datapath next values: config latch, row counter, window, output stage.
    always_comb begin
        row_cnt_d   = row_cnt_q;
        frac_x_d    = frac_x_q;
        frac_y_d    = frac_y_q;
        h_eff_d     = h_eff_q;
        window_d    = window_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            row_cnt_d = '0;
            if (START) begin
                frac_x_d = FRAC_X;
                frac_y_d = FRAC_Y;
                h_eff_d  = blk_h_clamped;
            end
        end else if (accept && row_cnt_q != last_row) begin
            row_cnt_d = row_cnt_q + CW'(1);
        end

        if (accept) begin
            window_d = win_new;
        end

        if (state_q == ST_RUN && accept) begin
            out_row_d   = p2_packed;
            out_valid_d = 1'b1;
            out_last_d  = (row_cnt_q == last_row);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (state_q == ST_FLUSH && out_hs) begin
            done_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_cnt_q   <= '0;
            frac_x_q    <= '0;
            frac_y_q    <= '0;
            h_eff_q     <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the window is only 8 x N_CH flops, so it is cleared on
            // reset; a large RAM-style buffer would normally be left unreset.
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < N_CH; c++) begin
                    window_q[r][c] <= '0;
                end
            end
        end else begin
            row_cnt_q   <= row_cnt_d;
            frac_x_q    <= frac_x_d;
            frac_y_q    <= frac_y_d;
            h_eff_q     <= h_eff_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            window_q    <= window_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_q;
    assign OUT_ROW   = out_row_q;
    assign OUT_LAST  = out_last_q;
    assign DONE      = done_q;

endmodule
